// File: rtl/hamming74_enc_stream.sv
// Streaming Hamming(7,4) SECDED encoder: one byte in, two 8-bit codewords out
// (low nibble first), with optional per-nibble XOR error injection and a counter.
module hamming74_enc_stream #(
    parameter bit ERR_INJ = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [7:0]  i_byte,
    input  logic [7:0]  i_inj_lo,
    input  logic [7:0]  i_inj_hi,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [6:0]  o_data,
    output logic        o_parity,
    output logic        o_last,
    output logic [15:0] o_inj_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2
    } state_t;

    // Returns {overall_parity, cw[6:0]} for one nibble.
    function automatic logic [7:0] enc74(input logic [3:0] d);
        logic [6:0] cw;
        cw[0] = d[0] ^ d[1] ^ d[3];
        cw[1] = d[0] ^ d[2] ^ d[3];
        cw[2] = d[0];
        cw[3] = d[1] ^ d[2] ^ d[3];
        cw[4] = d[1];
        cw[5] = d[2];
        cw[6] = d[3];
        return {^cw, cw};
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  byte_q, byte_d;
    logic [7:0]  inj_lo_q, inj_lo_d;
    logic [7:0]  inj_hi_q, inj_hi_d;
    logic [7:0]  out_q, out_d;
    logic [7:0]  cur_mask_q, cur_mask_d;
    logic        last_q, last_d;
    logic        valid_q, valid_d;
    logic [15:0] count_q, count_d;
    logic [7:0]  mask_lo_s, mask_hi_s;
    logic        ready_s;

    assign mask_lo_s = ERR_INJ ? i_inj_lo : 8'h00;
    assign mask_hi_s = ERR_INJ ? i_inj_hi : 8'h00;

    // Next-state, output-register and handshake logic.
    always_comb begin
        state_d    = state_q;
        byte_d     = byte_q;
        inj_lo_d   = inj_lo_q;
        inj_hi_d   = inj_hi_q;
        out_d      = out_q;
        cur_mask_d = cur_mask_q;
        last_d     = last_q;
        valid_d    = valid_q;
        ready_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready_s = 1'b1;
                if (i_valid) begin
                    byte_d     = i_byte;
                    inj_lo_d   = mask_lo_s;
                    inj_hi_d   = mask_hi_s;
                    out_d      = enc74(i_byte[3:0]) ^ mask_lo_s;
                    cur_mask_d = mask_lo_s;
                    last_d     = 1'b0;
                    valid_d    = 1'b1;
                    state_d    = ST_LO;
                end else begin
                    valid_d = 1'b0;
                end
            end
            ST_LO: begin
                ready_s = 1'b0;
                if (i_ready) begin
                    out_d      = enc74(byte_q[7:4]) ^ inj_hi_q;
                    cur_mask_d = inj_hi_q;
                    last_d     = 1'b1;
                    state_d    = ST_HI;
                end else begin
                    state_d = ST_LO;
                end
            end
            ST_HI: begin
                ready_s = i_ready;
                if (i_ready && i_valid) begin
                    byte_d     = i_byte;
                    inj_lo_d   = mask_lo_s;
                    inj_hi_d   = mask_hi_s;
                    out_d      = enc74(i_byte[3:0]) ^ mask_lo_s;
                    cur_mask_d = mask_lo_s;
                    last_d     = 1'b0;
                    state_d    = ST_LO;
                end else if (i_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HI;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        // Count the codeword leaving on this handshake, saturating.
        count_d = count_q;
        if (valid_q && i_ready && (cur_mask_q != 8'h00) && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end else begin
            count_d = count_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            byte_q     <= 8'h00;
            inj_lo_q   <= 8'h00;
            inj_hi_q   <= 8'h00;
            out_q      <= 8'h00;
            cur_mask_q <= 8'h00;
            last_q     <= 1'b0;
            valid_q    <= 1'b0;
            count_q    <= 16'h0000;
        end else begin
            state_q    <= state_d;
            byte_q     <= byte_d;
            inj_lo_q   <= inj_lo_d;
            inj_hi_q   <= inj_hi_d;
            out_q      <= out_d;
            cur_mask_q <= cur_mask_d;
            last_q     <= last_d;
            valid_q    <= valid_d;
            count_q    <= count_d;
        end
    end

    assign o_ready     = ready_s;
    assign o_valid     = valid_q;
    assign o_data      = out_q[6:0];
    assign o_parity    = out_q[7];
    assign o_last      = last_q;
    assign o_inj_count = count_q;

endmodule

// File: tb/tb_hamming74_enc_stream.sv
// Directed bench for hamming74_enc_stream; a second instance with ERR_INJ=0
// shares all inputs so injection gating can be compared side by side.
module tb_hamming74_enc_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        i_ready;
    logic [7:0]  i_byte;
    logic [7:0]  i_inj_lo;
    logic [7:0]  i_inj_hi;
    logic        o_ready,  o_valid,  o_parity,  o_last;
    logic [6:0]  o_data;
    logic [15:0] o_inj_count;
    logic        n_ready,  n_valid,  n_parity,  n_last;
    logic [6:0]  n_data;
    logic [15:0] n_inj_count;
    logic [10:0] obs, nobs;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    // obs = {valid, ready, last, parity, data[6:0]}
    assign obs  = {o_valid, o_ready, o_last, o_parity, o_data};
    assign nobs = {n_valid, n_ready, n_last, n_parity, n_data};

    hamming74_enc_stream #(.ERR_INJ(1'b1)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_byte(i_byte), .i_inj_lo(i_inj_lo), .i_inj_hi(i_inj_hi),
        .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
        .o_parity(o_parity), .o_last(o_last), .o_inj_count(o_inj_count)
    );

    hamming74_enc_stream #(.ERR_INJ(1'b0)) dut_noinj (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(n_ready),
        .i_byte(i_byte), .i_inj_lo(i_inj_lo), .i_inj_hi(i_inj_hi),
        .o_valid(n_valid), .i_ready(i_ready), .o_data(n_data),
        .o_parity(n_parity), .o_last(n_last), .o_inj_count(n_inj_count)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
        i_byte = 8'h00; i_inj_lo = 8'h00; i_inj_hi = 8'h00;
        tick(); tick();
        n_cmp++;
        if (obs !== 11'b01_0_0_0000000 || o_inj_count !== 16'h0000) begin
            n_err++; $display("FAIL reset_state got %b/%h want 01000000000/0000", obs, o_inj_count);
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (obs !== 11'b01_0_0_0000000) begin
            n_err++; $display("FAIL idle_after_reset got %b want 01000000000", obs);
        end
    endtask

    task automatic test_basic;
        i_valid = 1'b1; i_byte = 8'hA5; i_ready = 1'b1;
        tick();
        i_valid = 1'b0; #1;
        n_cmp++;
        if (obs !== {4'b1000, 7'h2D}) begin
            n_err++; $display("FAIL basic_lo got %b want %b", obs, {4'b1000, 7'h2D});
        end
        tick();
        n_cmp++;
        if (obs !== {4'b1111, 7'h52}) begin
            n_err++; $display("FAIL basic_hi got %b want %b", obs, {4'b1111, 7'h52});
        end
        tick();
        n_cmp++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_inj_count !== 16'h0000) begin
            n_err++; $display("FAIL basic_idle got v%b r%b cnt%h want v0 r1 cnt0000", o_valid, o_ready, o_inj_count);
        end
    endtask

    task automatic test_back_to_back;
        i_valid = 1'b1; i_byte = 8'h00; i_ready = 1'b1;
        tick();
        i_byte = 8'hFF; #1;
        n_cmp++;
        if (obs !== {4'b1000, 7'h00}) begin
            n_err++; $display("FAIL b2b_cw0 got %b want %b", obs, {4'b1000, 7'h00});
        end
        tick();
        n_cmp++;
        if (obs !== {4'b1110, 7'h00}) begin
            n_err++; $display("FAIL b2b_cw1 got %b want %b", obs, {4'b1110, 7'h00});
        end
        tick();
        i_valid = 1'b0; #1;
        n_cmp++;
        if (obs !== {4'b1001, 7'h7F}) begin
            n_err++; $display("FAIL b2b_cw2 got %b want %b", obs, {4'b1001, 7'h7F});
        end
        tick();
        n_cmp++;
        if (obs !== {4'b1111, 7'h7F}) begin
            n_err++; $display("FAIL b2b_cw3 got %b want %b", obs, {4'b1111, 7'h7F});
        end
        tick();
        n_cmp++;
        if (o_valid !== 1'b0) begin
            n_err++; $display("FAIL b2b_idle got v%b want v0", o_valid);
        end
    endtask

    task automatic test_stall;
        i_valid = 1'b1; i_byte = 8'hA5; i_ready = 1'b0;
        tick();
        i_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) tick();
            n_cmp++;
            if (obs !== {4'b1000, 7'h2D}) begin
                n_err++; $display("FAIL stall_lo_c%0d got %b want %b", c, obs, {4'b1000, 7'h2D});
            end
        end
        i_ready = 1'b1;
        tick();
        n_cmp++;
        if (obs !== {4'b1111, 7'h52}) begin
            n_err++; $display("FAIL stall_hi got %b want %b", obs, {4'b1111, 7'h52});
        end
        tick();
    endtask

    task automatic test_inject;
        i_valid = 1'b1; i_byte = 8'hA5; i_inj_lo = 8'h04; i_inj_hi = 8'h80; i_ready = 1'b1;
        tick();
        i_valid = 1'b0; i_inj_lo = 8'h00; i_inj_hi = 8'h00; #1;
        n_cmp++;
        if (obs !== {4'b1000, 7'h29} || (^obs[7:0]) !== 1'b1) begin
            n_err++; $display("FAIL inj_lo got %b want %b", obs, {4'b1000, 7'h29});
        end
        n_cmp++;
        if (nobs !== {4'b1000, 7'h2D}) begin
            n_err++; $display("FAIL noinj_lo got %b want %b", nobs, {4'b1000, 7'h2D});
        end
        tick();
        n_cmp++;
        if (obs !== {4'b1110, 7'h52} || (^obs[7:0]) !== 1'b1) begin
            n_err++; $display("FAIL inj_hi got %b want %b", obs, {4'b1110, 7'h52});
        end
        n_cmp++;
        if (nobs !== {4'b1111, 7'h52}) begin
            n_err++; $display("FAIL noinj_hi got %b want %b", nobs, {4'b1111, 7'h52});
        end
        tick();
        n_cmp++;
        if (o_inj_count !== 16'd2 || n_inj_count !== 16'd0) begin
            n_err++; $display("FAIL inj_count got %0d/%0d want 2/0", o_inj_count, n_inj_count);
        end
    endtask

    task automatic test_reset_mid;
        i_valid = 1'b1; i_byte = 8'hA5; i_ready = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        i_ready = 1'b0;
        tick();
        rst = 1'b1; #1;
        n_cmp++;
        if (obs !== 11'b01_0_0_0000000 || o_inj_count !== 16'h0000) begin
            n_err++; $display("FAIL reset_mid got %b/%h want 01000000000/0000", obs, o_inj_count);
        end
        tick();
        rst = 1'b0;
        i_valid = 1'b1; i_byte = 8'h3C; i_ready = 1'b1;
        tick();
        i_valid = 1'b0; #1;
        n_cmp++;
        if (obs !== {4'b1001, 7'h61}) begin
            n_err++; $display("FAIL post_rst_lo got %b want %b", obs, {4'b1001, 7'h61});
        end
        tick();
        n_cmp++;
        if (obs !== {4'b1110, 7'h1E}) begin
            n_err++; $display("FAIL post_rst_hi got %b want %b", obs, {4'b1110, 7'h1E});
        end
        tick();
    endtask

    task automatic test_saturate;
        int guard;
        i_valid = 1'b1; i_byte = 8'h5A; i_inj_lo = 8'h01; i_inj_hi = 8'h02; i_ready = 1'b1;
        guard = 0;
        while (o_inj_count != 16'hFFFF && guard < 70000) begin
            tick();
            guard++;
        end
        n_cmp++;
        if (o_inj_count !== 16'hFFFF) begin
            n_err++; $display("FAIL sat_reach got %h want ffff (timeout)", o_inj_count);
        end
        for (int c = 0; c < 6; c++) tick();
        n_cmp++;
        if (o_inj_count !== 16'hFFFF || n_inj_count !== 16'h0000) begin
            n_err++; $display("FAIL sat_hold got %h/%h want ffff/0000", o_inj_count, n_inj_count);
        end
        i_valid = 1'b0; i_inj_lo = 8'h00; i_inj_hi = 8'h00;
        tick(); tick(); tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_inject();
        test_reset_mid();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
